// File: rtl/jtag_tap_sequencer.sv
// jtag_tap_sequencer: turns host scan/reset/idle commands into TMS/TDI sequences and returns captured TDO
module jtag_tap_sequencer #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  input  logic               TDO,
  output logic               TMS,
  output logic               TDI,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data
);
  typedef enum logic [3:0] {RST, RST_IDLE, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RUN, RESP} state_t;
  localparam logic [1:0] OP_DR = 2'b00, OP_IR = 2'b01, OP_RST = 2'b10, OP_RUN = 2'b11;
  state_t state;
  logic [1:0] op;
  logic [LEN_W-1:0] len, cnt, nxt, cmd_l;
  logic [MAX_LEN-1:0] data, msk;
  logic last;
  assign cmd_l = (cmd_len == '0 || cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  assign cmd_ready = state == IDLE && !rsp_valid;
  assign nxt = cnt + LEN_W'(1);
  assign last = cnt == len - LEN_W'(1);
  // Sequencer: each state drives one registered TMS/TDI value per TCK cycle
  always_ff @(posedge TCK) begin
    if (TRST) begin
      state <= RST;
      cnt <= '0;
      op <= OP_DR;
      len <= '0;
      data <= '0;
      msk <= '0;
      TMS <= 1'b1;
      TDI <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
    end else begin
      case (state)
        RST: begin
          cnt <= nxt;
          if (cnt == LEN_W'(4)) begin
            state <= RST_IDLE;
            TMS <= 1'b0;
          end
        end
        RST_IDLE: begin
          state <= op == OP_RST ? RESP : IDLE;
          rsp_valid <= op == OP_RST;
        end
        IDLE: if (cmd_valid && cmd_ready) begin
          op <= cmd_op;
          len <= cmd_l;
          data <= cmd_data;
          rsp_data <= '0;
          msk <= MAX_LEN'(1);
          cnt <= '0;
          state <= cmd_op == OP_RST ? RST : cmd_op == OP_RUN ? RUN : SEL_DR;
          TMS <= cmd_op != OP_RUN;
        end
        SEL_DR: begin
          state <= op == OP_IR ? SEL_IR : CAPTURE;
          TMS <= op == OP_IR;
        end
        SEL_IR: begin
          state <= CAPTURE;
          TMS <= 1'b0;
        end
        CAPTURE: begin
          cnt <= cnt == '0 ? LEN_W'(1) : '0;
          if (cnt != '0) begin
            state <= SHIFT;
            TDI <= data[0];
            TMS <= len == LEN_W'(1);
          end
        end
        SHIFT: begin
          rsp_data <= rsp_data | (TDO ? msk : '0);
          msk <= msk << 1;
          if (last) begin
            state <= EXIT1;
            TMS <= 1'b1;
            TDI <= 1'b0;
          end else begin
            cnt <= nxt;
            data <= data >> 1;
            TDI <= data[1];
            TMS <= nxt == len - LEN_W'(1);
          end
        end
        EXIT1: begin
          state <= UPDATE;
          TMS <= 1'b0;
        end
        UPDATE: begin
          state <= RESP;
          rsp_valid <= 1'b1;
        end
        RUN: begin
          cnt <= nxt;
          if (last) begin
            state <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= RST;
          cnt <= '0;
          TMS <= 1'b1;
          TDI <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// tb_jtag_tap_sequencer: scoreboard bench driving the sequencer against a behavioural TAP controller
module tb_jtag_tap_sequencer;
  localparam int MAX_LEN = 32;
  localparam int LEN_W = 6;
  logic TCK = 1'b0, TRST = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b1;
  logic cmd_ready, TDO, TMS, TDI, rsp_valid;
  logic [1:0] cmd_op = 2'b00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic [31:0] rsp_data;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [31:0] data; int lat; logic [63:0] tms; logic [63:0] tdi;} exp_t;
  exp_t q[$];
  typedef enum logic [3:0] {TLR, RTI, SDS, CDR, SHDR, E1DR, PDR, E2DR, UDR, SIS, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
  tap_t tap;
  logic byp;
  logic [3:0] irs, ir;
  bit run = 0, pend = 0, seen = 0;
  int cyc = 0;
  logic [63:0] tr, td;

  always #5 TCK = ~TCK;

  jtag_tap_sequencer #(.MAX_LEN(MAX_LEN)) dut (
    .TCK(TCK), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .TDO(TDO),
    .TMS(TMS), .TDI(TDI), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string msg);
    n_chk++;
    n_fail++;
    $display("FAIL %s", msg);
  endtask

  // TAP controller model: bypass DR and 4-bit IR (capture value 0001)
  always @(posedge TCK) begin
    if (TRST) begin
      tap <= TLR;
      ir <= 4'hF;
    end else begin
      case (tap)
        TLR: tap <= TMS ? TLR : RTI;
        RTI: tap <= TMS ? SDS : RTI;
        SDS: tap <= TMS ? SIS : CDR;
        CDR: tap <= TMS ? E1DR : SHDR;
        SHDR: tap <= TMS ? E1DR : SHDR;
        E1DR: tap <= TMS ? UDR : PDR;
        PDR: tap <= TMS ? E2DR : PDR;
        E2DR: tap <= TMS ? UDR : SHDR;
        UDR: tap <= TMS ? SDS : RTI;
        SIS: tap <= TMS ? TLR : CIR;
        CIR: tap <= TMS ? E1IR : SHIR;
        SHIR: tap <= TMS ? E1IR : SHIR;
        E1IR: tap <= TMS ? UIR : PIR;
        PIR: tap <= TMS ? E2IR : PIR;
        E2IR: tap <= TMS ? UIR : SHIR;
        default: tap <= TMS ? SDS : RTI;
      endcase
      if (tap == CDR) byp <= 1'b0;
      if (tap == SHDR) byp <= TDI;
      if (tap == CIR) irs <= 4'b0001;
      if (tap == SHIR) irs <= {TDI, irs[3:1]};
      if (tap == UIR) ir <= irs;
    end
  end
  assign TDO = tap == SHIR ? irs[0] : byp;

  // Monitor: traces TMS/TDI from accept to rsp_valid and checks each response against the queue head
  always @(negedge TCK) begin
    #1;
    if (TRST) begin
      run = 0;
      pend = 0;
    end else begin
      if (pend) begin
        run = 1;
        seen = 0;
        cyc = 0;
        tr = '0;
        td = '0;
      end
      pend = cmd_valid && cmd_ready;
      if (run) begin
        cyc++;
        if (!rsp_valid && cyc <= 64) begin
          tr[6'(cyc - 1)] = TMS;
          td[6'(cyc - 1)] = TDI;
        end
        if (rsp_valid) begin
          if (q.size() == 0) begin
            fail($sformatf("rsp_unexpected: got data %0h, required no response", rsp_data));
            run = 0;
          end else begin
            if (!seen) begin
              chk("rsp_latency", 64'(cyc), 64'(q[0].lat));
              chk("tms_trace", tr, q[0].tms);
              chk("tdi_trace", td, q[0].tdi);
              seen = 1;
            end
            chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
            if (rsp_ready) begin
              q.delete(0);
              run = 0;
            end
          end
        end else if (seen) begin
          fail("rsp_valid_held: got 0 before rsp_ready, required 1");
          q.delete(0);
          run = 0;
        end else if (cyc > 200) begin
          fail($sformatf("rsp_timeout: got no rsp_valid in %0d cycles, required %0d", cyc, q.size() != 0 ? q[0].lat : 0));
          if (q.size() != 0) q.delete(0);
          run = 0;
        end
      end else if (rsp_valid) begin
        fail("rsp_unexpected: got rsp_valid=1 with no command running, required 0");
      end
    end
  end

  task automatic push_exp(input logic [1:0] op, input logic [31:0] d, input logic [31:0] er, input int lat, input logic [63:0] et);
    exp_t e;
    e.data = er;
    e.lat = lat;
    e.tms = et;
    e.tdi = op == 2'b00 ? 64'(d) << 3 : op == 2'b01 ? 64'(d) << 4 : 64'(0);
    q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [31:0] d, input logic [31:0] er, input int lat, input logic [63:0] et, input bit exp_rsp);
    int t = 0;
    if (exp_rsp) push_exp(op, d, er, lat, et);
    cmd_op = op;
    cmd_len = len;
    cmd_data = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 300) begin
      @(negedge TCK);
      t++;
    end
    chk("accept", cmd_ready, 1);
    @(negedge TCK);
    cmd_valid = 1'b0;
    cmd_op = ~op;
    cmd_len = len + 6'd7;
    cmd_data = ~d;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || !cmd_ready) && t < 300) begin
      @(negedge TCK);
      t++;
    end
    chk("drain", 64'(q.size()), 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tms"}, TMS, 1);
    chk({tag, "_tdi"}, TDI, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 0);
  endtask

  task automatic powerup(input string tag);
    @(negedge TCK);
    TRST = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("%s_tms_c%0d", tag, k), TMS, 64'(k < 6));
      chk($sformatf("%s_ready_c%0d", tag, k), cmd_ready, 64'(k == 7));
      if (k < 7) @(negedge TCK);
    end
    chk({tag, "_tap_rti"}, 64'(tap == RTI), 1);
  endtask

  initial begin
    repeat (3) @(negedge TCK);
    check_reset("reset");
    powerup("powerup");
    issue(2'b00, 6'd8, 32'hA5, 32'h4A, 14, 64'h0C01, 1);
    drain();
    chk("dr_tap_rti", 64'(tap == RTI), 1);
    issue(2'b01, 6'd4, 32'h3, 32'h1, 11, 64'h183, 1);
    drain();
    chk("ir_tap_rti", 64'(tap == RTI), 1);
    chk("ir_loaded", 64'(ir), 64'h3);
    rsp_ready = 1'b0;
    issue(2'b00, 6'd2, 32'h1, 32'h2, 8, 64'h31, 1);
    push_exp(2'b11, 32'h0, 32'h0, 3, 64'h0);
    cmd_op = 2'b11;
    cmd_len = 6'd2;
    cmd_data = 32'h0;
    cmd_valid = 1'b1;
    begin
      int t = 0;
      while (!rsp_valid && t < 100) begin
        @(negedge TCK);
        t++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_rsp_valid", rsp_valid, 1);
      @(negedge TCK);
    end
    rsp_ready = 1'b1;
    chk("handshake_cmd_ready", cmd_ready, 0);
    @(negedge TCK);
    chk("ready_after_rsp", cmd_ready, 1);
    @(negedge TCK);
    cmd_valid = 1'b0;
    drain();
    issue(2'b00, 6'd16, 32'hBEEF, 32'h0, 0, 64'h0, 0);
    repeat (6) @(negedge TCK);
    chk("abort_tap_shift", 64'(tap == SHDR), 1);
    chk("abort_tdi_bit3", TDI, 1);
    chk("abort_tms", TMS, 0);
    TRST = 1'b1;
    repeat (2) @(negedge TCK);
    check_reset("abort_reset");
    powerup("repowerup");
    chk("abort_rsp_data", 64'(rsp_data), 0);
    issue(2'b00, 6'd0, 32'h8000_0001, 32'h2, 38, 64'h0000_000C_0000_0001, 1);
    issue(2'b00, 6'd40, 32'hFFFF_0000, 32'hFFFE_0000, 38, 64'h0000_000C_0000_0001, 1);
    issue(2'b00, 6'd1, 32'h1, 32'h0, 7, 64'h19, 1);
    issue(2'b11, 6'd3, 32'h0, 32'h0, 4, 64'h0, 1);
    issue(2'b10, 6'd0, 32'h0, 32'h0, 7, 64'h1F, 1);
    drain();
    chk("final_tap_rti", 64'(tap == RTI), 1);
    repeat (5) @(negedge TCK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, required earlier");
    $fatal(1, "watchdog");
  end
endmodule
